// File: rtl/mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mem_ctrl
// Brief    : Single-port byte-enabled data memory with valid/ready requests,
//            a registered read response, and a zero-init sweep after reset.
//            Optional per-byte parity when MEM_PARITY_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module mem_ctrl #(
    parameter int DATA_W        = 32,
    parameter int DEPTH         = 1024,
    parameter int ADDR_W        = $clog2(DEPTH),
    parameter bit INIT_ON_RESET = 1'b1
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              in_mem_req_valid,
    output logic              out_mem_req_ready,
    input  logic [ADDR_W-1:0] in_mem_addr,
    input  logic              in_mem_re_web,
    input  logic [DATA_W-1:0] in_mem_write_data,
    input  logic [DATA_W/8-1:0] in_mem_byte_en,
`ifdef MEM_PARITY_EN
    input  logic              in_mem_par_inject,
`endif
    output logic              out_mem_rsp_valid,
    input  logic              in_mem_rsp_ready,
    output logic [DATA_W-1:0] out_mem_data,
    output logic              out_mem_init_done,
    output logic              out_mem_err
);

    localparam int c_NB = DATA_W / 8;

    typedef enum logic [0:0] {
        S_INIT = 1'b0,
        S_IDLE = 1'b1
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [ADDR_W-1:0]   r_init_cnt;
    logic                w_init_last;
    logic                w_init_we;
    logic                w_in_range;
    logic                w_accept;
    logic                w_wr;
    logic                w_rd;
    logic [DATA_W-1:0]   w_rd_word;
    logic                w_rd_err;
    logic                r_rsp_valid;
    logic [DATA_W-1:0]   r_rsp_data;
    logic [DATA_W-1:0]   r_mem [DEPTH];

    assign w_init_last = (r_init_cnt == ADDR_W'(DEPTH - 1));
    assign w_in_range  = ({1'b0, in_mem_addr} < (ADDR_W + 1)'(DEPTH));
    assign w_accept    = in_mem_req_valid && out_mem_req_ready;
    assign w_wr        = w_accept && !in_mem_re_web && w_in_range;
    assign w_rd        = w_accept && in_mem_re_web;
    assign w_rd_word   = w_in_range ? r_mem[in_mem_addr] : '0;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= S_INIT;
            r_init_cnt <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == S_INIT && !w_init_last) begin
                r_init_cnt <= r_init_cnt + ADDR_W'(1);
            end
        end
    end

    always_comb begin
        w_state_nxt       = r_state;
        out_mem_req_ready = 1'b0;
        out_mem_init_done = 1'b0;
        w_init_we         = 1'b0;
        case (r_state)
            S_INIT: begin
                w_init_we = INIT_ON_RESET;
                if (!INIT_ON_RESET || w_init_last) begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_IDLE: begin
                out_mem_init_done = 1'b1;
                out_mem_req_ready = !r_rsp_valid || in_mem_rsp_ready;
            end
            default: w_state_nxt = S_INIT;
        endcase
    end

    // Out-of-range writes are dropped via w_wr; nothing lands while in reset.
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            if (w_init_we) begin
                r_mem[r_init_cnt] <= '0;
            end else if (w_wr) begin
                for (int b = 0; b < c_NB; b++) begin
                    if (in_mem_byte_en[b]) begin
                        r_mem[in_mem_addr][8*b +: 8] <= in_mem_write_data[8*b +: 8];
                    end
                end
            end
        end
    end

`ifdef MEM_PARITY_EN
    logic [c_NB-1:0] r_par [DEPTH];
    logic [c_NB-1:0] w_rd_par;
    logic            r_rsp_err;

    assign w_rd_par = w_in_range ? r_par[in_mem_addr] : '0;

    // Stored bit is the even-parity bit of the byte, optionally inverted.
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            if (w_init_we) begin
                r_par[r_init_cnt] <= '0;
            end else if (w_wr) begin
                for (int b = 0; b < c_NB; b++) begin
                    if (in_mem_byte_en[b]) begin
                        r_par[in_mem_addr][b] <= (^in_mem_write_data[8*b +: 8]) ^ in_mem_par_inject;
                    end
                end
            end
        end
    end

    always_comb begin
        w_rd_err = 1'b0;
        for (int b = 0; b < c_NB; b++) begin
            w_rd_err = w_rd_err | ((^w_rd_word[8*b +: 8]) ^ w_rd_par[b]);
        end
        if (!w_in_range) begin
            w_rd_err = 1'b0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_rsp_err <= 1'b0;
        end else if (w_rd) begin
            r_rsp_err <= w_rd_err;
        end
    end

    assign out_mem_err = r_rsp_err;
`else
    assign w_rd_err    = 1'b0;
    assign out_mem_err = w_rd_err;
`endif

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= '0;
        end else if (w_rd) begin
            r_rsp_valid <= 1'b1;
            r_rsp_data  <= w_rd_word;
        end else if (in_mem_rsp_ready) begin
            r_rsp_valid <= 1'b0;
        end
    end

    assign out_mem_rsp_valid = r_rsp_valid;
    assign out_mem_data      = r_rsp_data;

endmodule
`default_nettype wire

// File: tb/tb_mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_ctrl
// Brief    : Scoreboard bench for mem_ctrl; one DUT with DEPTH=16 and one with
//            DEPTH=12 share stimulus, selected by sel.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_ctrl;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        re_web = 1'b0;
    logic        rsp_ready = 1'b1;
    logic        inject = 1'b0;
    logic [3:0]  addr = '0;
    logic [31:0] wdata = '0;
    logic [3:0]  be = '0;
    int          sel = 0;

    int vectors = 0;
    int miscompares = 0;

    typedef struct packed {
        logic [31:0] d;
        logic        e;
    } exp_t;
    exp_t q[$];

    logic [31:0] mdl  [2][16];
    logic [3:0]  mbad [2][16];

    logic        v16, v12;
    logic        rdy16, rv16, done16, err16;
    logic        rdy12, rv12, done12, err12;
    logic [31:0] d16, d12;
    logic        rdy, rv, done, err;
    logic [31:0] dout;

    assign v16  = req_valid && (sel == 0);
    assign v12  = req_valid && (sel == 1);
    assign rdy  = (sel == 1) ? rdy12  : rdy16;
    assign rv   = (sel == 1) ? rv12   : rv16;
    assign done = (sel == 1) ? done12 : done16;
    assign err  = (sel == 1) ? err12  : err16;
    assign dout = (sel == 1) ? d12    : d16;

    mem_ctrl #(.DATA_W(32), .DEPTH(16), .INIT_ON_RESET(1'b1)) dut16 (
        .i_clk(clk), .i_rst(rst),
        .in_mem_req_valid(v16), .out_mem_req_ready(rdy16),
        .in_mem_addr(addr), .in_mem_re_web(re_web),
        .in_mem_write_data(wdata), .in_mem_byte_en(be),
`ifdef MEM_PARITY_EN
        .in_mem_par_inject(inject),
`endif
        .out_mem_rsp_valid(rv16), .in_mem_rsp_ready(rsp_ready),
        .out_mem_data(d16), .out_mem_init_done(done16), .out_mem_err(err16)
    );

    mem_ctrl #(.DATA_W(32), .DEPTH(12), .INIT_ON_RESET(1'b1)) dut12 (
        .i_clk(clk), .i_rst(rst),
        .in_mem_req_valid(v12), .out_mem_req_ready(rdy12),
        .in_mem_addr(addr), .in_mem_re_web(re_web),
        .in_mem_write_data(wdata), .in_mem_byte_en(be),
`ifdef MEM_PARITY_EN
        .in_mem_par_inject(inject),
`endif
        .out_mem_rsp_valid(rv12), .in_mem_rsp_ready(rsp_ready),
        .out_mem_data(d12), .out_mem_init_done(done12), .out_mem_err(err12)
    );

    // Model update and scoreboard, sampled on the falling edge ahead of the
    // rising edge at which handshakes complete.
    always @(negedge clk) begin
        if (!rst) begin
            if (rv && rsp_ready) begin
                vectors++;
                if (q.size() == 0) begin
                    miscompares++;
                    $display("FAIL rsp_unexpected: got data %h, expected no response", dout);
                end else begin
                    exp_t x;
                    x = q.pop_front();
                    if (dout !== x.d || err !== x.e) begin
                        miscompares++;
                        $display("FAIL rsp_data: got %h err %b, expected %h err %b", dout, err, x.d, x.e);
                    end
                end
            end
            if (req_valid && rdy) begin
                int depth;
                depth = (sel == 1) ? 12 : 16;
                if (re_web) begin
                    exp_t x;
                    if (int'(addr) < depth) begin
                        x.d = mdl[sel][addr];
                        x.e = |mbad[sel][addr];
                    end else begin
                        x.d = '0;
                        x.e = 1'b0;
                    end
                    q.push_back(x);
                end else if (int'(addr) < depth) begin
                    for (int b = 0; b < 4; b++) begin
                        if (be[b]) begin
                            mdl[sel][addr][8*b +: 8] = wdata[8*b +: 8];
                            mbad[sel][addr][b] = inject;
                        end
                    end
                end
            end
        end
    end

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        q.delete();
        for (int s = 0; s < 2; s++)
            for (int a = 0; a < 16; a++) begin
                mdl[s][a]  = '0;
                mbad[s][a] = '0;
            end
    endtask

    task automatic req(input logic rd, input logic [3:0] a, input logic [31:0] d,
                       input logic [3:0] b, input logic inj, output int cyc);
        logic acc;
        req_valid = 1'b1; re_web = rd; addr = a; wdata = d; be = b; inject = inj;
        acc = 1'b0;
        cyc = 0;
        while (!acc && cyc < 50) begin
            @(negedge clk);
            acc = rdy;
            @(posedge clk); #1;
            cyc++;
        end
        req_valid = 1'b0;
        if (!acc) begin
            vectors++;
            miscompares++;
            $display("FAIL req_timeout: got no accept in %0d cycles, expected accept", cyc);
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        rsp_ready = 1'b1;
        while (q.size() != 0 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        vectors++;
        if (q.size() != 0 || rv !== 1'b0) begin
            miscompares++;
            $display("FAIL drain: got %0d pending, rsp_valid %b, expected 0 pending, rsp_valid 0", q.size(), rv);
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        vectors++;
        if (act !== expv) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", name, act, expv);
        end
    endtask

    task automatic count_init(input string name, input int expv);
        int k16;
        k16 = -1;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk); #1;
            if (k16 < 0 && rdy16) k16 = k;
        end
        check(name, k16, expv);
    endtask

    task automatic test_reset();
        int k16, k12;
        sel = 0;
        do_reset();
        check("rst_ready", rdy16, 0);
        check("rst_rsp_valid", rv16, 0);
        check("rst_data", d16, 0);
        check("rst_err", err16, 0);
        check("rst_init_done", done16, 0);
        k16 = -1; k12 = -1;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk); #1;
            if (k16 < 0 && rdy16) k16 = k;
            if (k12 < 0 && rdy12) k12 = k;
        end
        check("init_cycles_16", k16, 16);
        check("init_cycles_12", k12, 12);
        check("init_done_16", done16, 1);
    endtask

    task automatic test_init_read();
        int c;
        sel = 0; rsp_ready = 1'b1;
        req(1'b1, 4'd5, 32'h0, 4'h0, 1'b0, c);
        check("init_read_valid", rv, 1);
        check("init_read_data", dout, 32'h0000_0000);
        drain();
    endtask

    task automatic test_byte_enable();
        int c;
        sel = 0; rsp_ready = 1'b1;
        req(1'b0, 4'd3, 32'hAABB_CCDD, 4'b1111, 1'b0, c);
        req(1'b0, 4'd3, 32'h1122_3344, 4'b0101, 1'b0, c);
        req(1'b0, 4'd3, 32'hFFFF_FFFF, 4'b0000, 1'b0, c);
        req(1'b1, 4'd3, 32'h0, 4'h0, 1'b0, c);
        check("byte_en_data", dout, 32'hAA22_CC44);
        drain();
    endtask

    task automatic test_backpressure();
        int c;
        sel = 0; rsp_ready = 1'b1;
        req(1'b0, 4'd1, 32'h1, 4'hF, 1'b0, c);
        req(1'b0, 4'd2, 32'h2, 4'hF, 1'b0, c);
        rsp_ready = 1'b0;
        req(1'b1, 4'd1, 32'h0, 4'h0, 1'b0, c);
        req_valid = 1'b1; re_web = 1'b1; addr = 4'd2;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("bp_hold_data", dout, 32'h1);
            check("bp_hold_ready", {rv, rdy}, 2'b10);
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        check("bp_second_data", dout, 32'h2);
        check("bp_second_valid", rv, 1);
        drain();
    endtask

    task automatic test_raw();
        int c;
        sel = 0; rsp_ready = 1'b1;
        req(1'b0, 4'd7, 32'hDEAD_BEEF, 4'hF, 1'b0, c);
        req(1'b1, 4'd7, 32'h0, 4'h0, 1'b0, c);
        check("raw_data", dout, 32'hDEAD_BEEF);
        drain();
    endtask

    task automatic test_back_to_back();
        int c;
        sel = 0; rsp_ready = 1'b1;
        for (int a = 8; a < 16; a++)
            req(1'b0, 4'(a), $urandom, 4'($urandom_range(15)), 1'b0, c);
        for (int a = 8; a < 16; a++) begin
            req(1'b1, 4'(a), 32'h0, 4'h0, 1'b0, c);
            check("b2b_accept_cycles", c, 1);
        end
        drain();
    endtask

    task automatic test_out_of_range();
        int c;
        sel = 1; rsp_ready = 1'b1;
        req(1'b0, 4'd2, 32'hCAFE_F00D, 4'hF, 1'b0, c);
        req(1'b0, 4'd14, 32'hFFFF_FFFF, 4'hF, 1'b0, c);
        req(1'b1, 4'd14, 32'h0, 4'h0, 1'b0, c);
        check("oor_read_data", dout, 32'h0);
        check("oor_read_err", err, 0);
        req(1'b1, 4'd2, 32'h0, 4'h0, 1'b0, c);
        check("oor_no_alias", dout, 32'hCAFE_F00D);
        req(1'b1, 4'd11, 32'h0, 4'h0, 1'b0, c);
        drain();
        sel = 0;
    endtask

    task automatic test_reset_mid();
        int c;
        sel = 0; rsp_ready = 1'b1;
        req(1'b0, 4'd9, 32'h5555_AAAA, 4'hF, 1'b0, c);
        rsp_ready = 1'b0;
        req(1'b1, 4'd9, 32'h0, 4'h0, 1'b0, c);
        check("mid_pending", rv, 1);
        do_reset();
        check("mid_rsp_dropped", rv, 0);
        check("mid_ready", rdy, 0);
        check("mid_init_done", done, 0);
        repeat (5) @(posedge clk);
        #1;
        do_reset();
        count_init("mid_restart_cycles", 16);
        rsp_ready = 1'b1;
        req(1'b1, 4'd9, 32'h0, 4'h0, 1'b0, c);
        check("mid_zeroed", dout, 32'h0);
        drain();
    endtask

`ifdef MEM_PARITY_EN
    task automatic test_parity();
        int c;
        sel = 0; rsp_ready = 1'b1;
        req(1'b0, 4'd4, 32'h1234_5678, 4'b0010, 1'b1, c);
        req(1'b1, 4'd4, 32'h0, 4'h0, 1'b0, c);
        check("par_err_set", err, 1);
        drain();
        req(1'b0, 4'd4, 32'h1234_5678, 4'b1111, 1'b0, c);
        req(1'b1, 4'd4, 32'h0, 4'h0, 1'b0, c);
        check("par_err_clear", err, 0);
        drain();
    endtask
`endif

    initial begin
        test_reset();
        test_init_read();
        test_byte_enable();
        test_backpressure();
        test_raw();
        test_back_to_back();
        test_out_of_range();
        test_reset_mid();
`ifdef MEM_PARITY_EN
        test_parity();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
